// File: rtl/fft_input_buffer.sv
// 32-point FFT input buffer: writes real samples into bit-reversed slots and holds full frames for the butterfly stage.
// Optional macro FFT_PINGPONG_EN adds a second bank so filling continues while a frame is held.
module fft_input_buffer #(
    parameter int SAMP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    input  logic [SAMP_W-1:0]       s_data,
    output logic                    s_ready,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic [32*2*SAMP_W-1:0]  frame_data,
    output logic [4:0]              wr_cnt
);
    localparam int N  = 32;
    localparam int SW = 2 * SAMP_W;
`ifdef FFT_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic {FILL, HOLD} state_t;

    state_t     state_q, state_d;
    logic [1:0] nfull_q, nfull_d;
    logic       ready_q, ready_d;
    logic       fvalid_q, fvalid_d;
    logic [4:0] cnt_q;
    logic       fill_sel, rd_sel;
    logic       accept, complete, rel;

    logic [NB-1:0][N-1:0][SW-1:0] bank_q;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    assign accept   = s_valid && ready_q;
    assign complete = accept && (cnt_q == 5'd31);
    assign rel      = frame_ack && fvalid_q;

    // nfull counts completed banks awaiting ack; HOLD means no bank is free to fill
    always_comb begin
        nfull_d = nfull_q;
        if (complete && !rel)
            nfull_d = nfull_q + 2'd1;
        else if (rel && !complete)
            nfull_d = nfull_q - 2'd1;
        state_d  = (nfull_d == 2'(NB)) ? HOLD : FILL;
        ready_d  = (state_d == FILL);
        fvalid_d = (nfull_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            nfull_q  <= 2'd0;
            ready_q  <= 1'b1;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            nfull_q  <= nfull_d;
            ready_q  <= ready_d;
            fvalid_q <= fvalid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 5'd0;
            bank_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 5'd1;
            bank_q[fill_sel][bitrev5(cnt_q)] <= {{SAMP_W{1'b0}}, s_data};
        end
    end

`ifdef FFT_PINGPONG_EN
    // Banks alternate, so the read pointer toggling on each ack keeps completion order
    logic fill_sel_q, rd_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            if (complete) fill_sel_q <= ~fill_sel_q;
            if (rel)      rd_sel_q   <= ~rd_sel_q;
        end
    end

    assign fill_sel = fill_sel_q;
    assign rd_sel   = rd_sel_q;
`else
    assign fill_sel = 1'b0;
    assign rd_sel   = 1'b0;
`endif

    assign s_ready     = ready_q;
    assign frame_valid = fvalid_q;
    assign frame_data  = bank_q[rd_sel];
    assign wr_cnt      = cnt_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Bench for fft_input_buffer: vector table, directed corner sequences and random traffic against a frame-queue model.
module tb_fft_input_buffer;
    localparam int SW = 16;
`ifdef FFT_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            s_valid = 1'b0;
    logic [7:0]      s_data = 8'h00;
    logic            frame_ack = 1'b0;
    logic            s_ready, frame_valid;
    logic [32*SW-1:0] frame_data;
    logic [4:0]      wr_cnt;

    always #5 clk = ~clk;

    fft_input_buffer #(.SAMP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_data(frame_data), .wr_cnt(wr_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: completed frames wait in a queue (capacity NB), samples kept in arrival order
    typedef logic [31:0][7:0] frame_t;
    frame_t q[$];
    frame_t part;
    int     cnt = 0;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       ack;
        logic       rdy;
        logic       vld;
        logic [4:0] cnt;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [4:0] rev(input int k);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[4-b] = k[b];
        return r;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [32*SW-1:0] act, input logic [32*SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check(input string name);
        logic [32*SW-1:0] exp;
        frame_t f;
        chk32({name, " s_ready"}, 32'(s_ready), 32'(q.size() < NB));
        chk32({name, " frame_valid"}, 32'(frame_valid), 32'(q.size() > 0));
        chk32({name, " wr_cnt"}, 32'(wr_cnt), cnt);
        if (q.size() > 0) begin
            f = q[0];
            for (int k = 0; k < 32; k++) exp[SW*k +: SW] = {8'h00, f[rev(k)]};
            chkw({name, " frame_data"}, frame_data, exp);
        end
    endtask

    task automatic step(input string name, input logic sv, input logic [7:0] sd, input logic ack);
        logic acc, rel;
        s_valid = sv; s_data = sd; frame_ack = ack;
        acc = sv && (q.size() < NB);
        rel = ack && (q.size() > 0);
        @(posedge clk);
        if (rel) q.delete(0);
        if (acc) begin
            part[cnt] = sd;
            cnt++;
            if (cnt == 32) begin
                q.push_back(part);
                cnt = 0;
            end
        end
        #1;
        model_check(name);
    endtask

    task automatic async_reset(input string name);
        s_valid = 1'b0; frame_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        cnt = 0;
        chk32({name, " s_ready"}, 32'(s_ready), 32'd1);
        chk32({name, " frame_valid"}, 32'(frame_valid), 32'd0);
        chk32({name, " wr_cnt"}, 32'(wr_cnt), 32'd0);
        chkw({name, " frame_data"}, frame_data, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [32*SW-1:0] snap;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[1] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[2] = '{1'b0, 8'h09, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 5'd2};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 5'd3};

        #1 rst_n = 1'b0;
        #2;
        chk32("reset s_ready", 32'(s_ready), 32'd1);
        chk32("reset frame_valid", 32'(frame_valid), 32'd0);
        chk32("reset wr_cnt", 32'(wr_cnt), 32'd0);
        chkw("reset frame_data", frame_data, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step("table", tbl[i].sv, tbl[i].sd, tbl[i].ack);
            chk32("table s_ready", 32'(s_ready), 32'(tbl[i].rdy));
            chk32("table frame_valid", 32'(frame_valid), 32'(tbl[i].vld));
            chk32("table wr_cnt", 32'(wr_cnt), 32'(tbl[i].cnt));
        end
        async_reset("reset after table");

        // Ramp frame: slot k must hold bitrev5(k)
        for (int n = 0; n < 32; n++) step("ramp", 1'b1, 8'(n), 1'b0);
        chk32("ramp frame_valid", 32'(frame_valid), 32'd1);
        chk32("ramp slot1", 32'(frame_data[SW*1 +: SW]), 32'h0010);
        chk32("ramp slot2", 32'(frame_data[SW*2 +: SW]), 32'h0008);
        chk32("ramp slot31", 32'(frame_data[SW*31 +: SW]), 32'h001F);

        snap = frame_data;
        for (int i = 0; i < 10; i++) step("hold stall", 1'b1, 8'hFF, 1'b0);
`ifndef FFT_PINGPONG_EN
        chkw("hold data stable", frame_data, snap);
        chk32("hold wr_cnt", 32'(wr_cnt), 32'd0);
`endif

        step("ack", 1'b0, 8'h00, 1'b1);
        for (int n = 0; n < 32; n++) step("frame 80", 1'b1, 8'(8'h80 + n), 1'b0);
        step("ack 80", 1'b0, 8'h00, 1'b1);
        step("ack idle", 1'b0, 8'h00, 1'b1);

        for (int n = 0; n < 17; n++) step("partial", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        async_reset("mid-frame reset");
        for (int n = 0; n < 32; n++) step("post reset", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        step("post reset ack", 1'b0, 8'h00, 1'b1);

`ifdef FFT_PINGPONG_EN
        async_reset("pp reset");
        for (int n = 0; n < 64; n++) step("pp fill", 1'b1, 8'(n), 1'b0);
        chk32("pp full s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 3; i++) step("pp stall", 1'b1, 8'd64, 1'b0);
        step("pp ack", 1'b1, 8'd64, 1'b1);
        chk32("pp ack s_ready", 32'(s_ready), 32'd1);
        for (int n = 64; n < 96; n++) step("pp frame3", 1'b1, 8'(n), 1'b0);
        step("pp ack2", 1'b0, 8'h00, 1'b1);
        step("pp ack3", 1'b0, 8'h00, 1'b1);
`endif

        for (int i = 0; i < 600; i++)
            step("random", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 5) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
